joy_dir_filter: RTL and testbench
=================================

Name: joy_dir_filter

Overview:
- Parametrised successor to the per-player 4-way direction restrictor.
- Sits between the joystick mux (USB / DB9MD / DB15) and the core input bytes.
- Per player: synchronises and debounces raw directions, applies a selectable restriction mode (raw, SOCD-neutral 8-way, 4-way last-wins, 4-way first-wins), then a selectable 90° rotation for rotated cabinets.
- One instance serves all players.

Parameters:
- NUM_PLAYERS, 2, number of independent direction channels (1..4).
- DEBOUNCE_W, 4, debounce counter width; a change must persist for 2^DEBOUNCE_W-1 consecutive ce ticks (min 1).
- AF_W, 4, autofire half-period counter width (used only with the optional feature).

Ports:
- clk_sys, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- ce, in, 1, debounce/autofire time-base tick, one clk_sys cycle wide.
- mode, in, 2, restriction mode for all players: 0 raw, 1 8-way SOCD-neutral, 2 4-way last-pressed-wins, 3 4-way first-pressed-wins.
- rotate, in, 2, 0 none, 1 CW, 2 180°, 3 CCW.
- dir_in, in, 4*NUM_PLAYERS, raw directions; player p occupies [4p+3:4p] as {up,down,left,right}; active high.
- dir_out, out, 4*NUM_PLAYERS, filtered directions, same packing.
- dir_valid, out, NUM_PLAYERS, 1-cycle pulse when the player's dir_out changes.

Behaviour:
- Reset (async, active high): dir_out=0, dir_valid=0, sync flops=0, debounced state=0, debounce counters=0, masks=4'b1111. Release takes effect on the next clk_sys edge.
- Synchroniser: 2-flop per bit; dir_in to synced is 2 cycles.
- Debounce, per bit:
  - synced==stable: counter cleared.
  - Otherwise, counter +1 on each ce.
  - Counter reaching all-ones: stable<=synced, counter<=0, on the same edge.
  - A glitch that returns before all-ones clears the counter; no change.
  - ce low: counter holds.
- Edge detect: new[i] = stable[i] & ~stable_d[i], where stable_d is the stable value from the previous cycle.
- Mode 0: filt = stable.
- Mode 1:
  - up&down both set: both vertical bits 0.
  - left&right both set: both horizontal bits 0.
  - Diagonals pass.
- Mode 2 (last wins):
  - Any new[i]: mask<=onehot(i). Simultaneous new edges: highest index wins (up > down > left > right).
  - (stable & mask)==0: mask<=1111. This overrides the new-edge rule only when no new edge occurs in the same cycle.
  - filt = stable & mask_next, computed combinationally, so no multi-bit output cycle when pressing from neutral.
- Mode 3 (first wins):
  - mask==1111 and stable!=0: mask<=onehot(highest set bit of stable).
  - New edges ignored while mask is one-hot and still held.
  - Held bit released: mask<=1111.
  - filt = stable & mask_next.
- mode change (mode != mode_d): all masks<=1111 that cycle; filt uses 1111.
- Rotation, applied to filt:
  - CW: up→right, right→down, down→left, left→up.
  - 180: up↔down, left↔right.
  - CCW is the inverse of CW.
  - rotate changes take effect the next cycle; no mask reset.
- Output: dir_out registered; dir_valid[p] = (new dir_out[p] != old dir_out[p]) on the same edge.
- Total latency, raw input to output with debounce satisfied: 2 sync cycles + debounce interval + 1 register cycle.

Optional Feature:
- Macro JOY_DIR_FILTER_AUTOFIRE_EN.
- When defined, the block adds:
  - Ports fire_in [NUM_PLAYERS], af_en [NUM_PLAYERS], fire_out [NUM_PLAYERS], registered.
  - fire_in is synced and debounced like the direction bits.
  - af_en[p]=0: fire_out = debounced fire.
  - af_en[p]=1 while fire held: fire_out toggles every 2^AF_W ce ticks, starting high on the press edge; release forces 0 and clears the counter next cycle.
  - fire_out resets to 0.
- When not defined: none of these ports or counters exist.

Decomposition:
- Package joy_dir_pkg holds:
  - mode enum: MODE_RAW, MODE_SOCD, MODE_LAST, MODE_FIRST.
  - rotate enum: ROT_NONE, ROT_CW, ROT_180, ROT_CCW.
  - Bit index constants DIR_UP=3, DIR_DN=2, DIR_LT=1, DIR_RT=0.
  - Rotation function.
- Sub-module joy_dir_chan covers one player's sync, debounce, mask and rotation. The top generates NUM_PLAYERS instances and packs the buses.

Test Plan (DEBOUNCE_W=2, ce every 4 cycles):
- Reset mid-debounce with up pending 2 ticks → dir_out=0000 immediately; after release, up needs 3 full ce ticks to appear as 1000.
- 1-tick glitch on left → dir_out stays 0000; dir_valid never pulses.
- Mode 2: hold right, then add up → 0001 then 1000; release up while right held → 0001 on the cycle after mask reset.
- Mode 3: hold right, add up → stays 0001; release right with up held → 1000.
- Mode 1: left+right+up held → 1000. Mode 0, same input → 1011.
- rotate=1, mode 0, up held → 0001; rotate=2 → 0100, dir_valid pulses once per change. With JOY_DIR_FILTER_AUTOFIRE_EN, AF_W=1, af_en=1, fire held → fire_out toggles every 2 ce ticks, first level high.

Source files
------------

// File: rtl/joy_dir_pkg.sv
// ---------------------------------------------------------------------------
// joy_dir_pkg
// Shared types and helpers for the joystick direction filter.
//   mode_e     : restriction mode (raw, SOCD-neutral, 4-way last, 4-way first)
//   rotate_e   : cabinet rotation (none, CW, 180, CCW)
//   DIR_*      : bit positions inside a player's {up,down,left,right} nibble
//   rotate_dir : remaps a direction nibble for a rotated cabinet
//   onehot_hi  : one-hot of the highest set bit (up > down > left > right)
//   socd_neutral : cancels opposing directions, keeps diagonals
// ---------------------------------------------------------------------------
package joy_dir_pkg;

    typedef enum logic [1:0] {
        MODE_RAW   = 2'd0,
        MODE_SOCD  = 2'd1,
        MODE_LAST  = 2'd2,
        MODE_FIRST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_180  = 2'd2,
        ROT_CCW  = 2'd3
    } rotate_e;

    localparam int DIR_UP = 3;
    localparam int DIR_DN = 2;
    localparam int DIR_LT = 1;
    localparam int DIR_RT = 0;

    function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rotate_e rot);
        logic [3:0] r;
        r = d;
        case (rot)
            ROT_CW: begin
                r[DIR_RT] = d[DIR_UP];
                r[DIR_DN] = d[DIR_RT];
                r[DIR_LT] = d[DIR_DN];
                r[DIR_UP] = d[DIR_LT];
            end
            ROT_180: begin
                r[DIR_DN] = d[DIR_UP];
                r[DIR_UP] = d[DIR_DN];
                r[DIR_RT] = d[DIR_LT];
                r[DIR_LT] = d[DIR_RT];
            end
            ROT_CCW: begin
                r[DIR_LT] = d[DIR_UP];
                r[DIR_DN] = d[DIR_LT];
                r[DIR_RT] = d[DIR_DN];
                r[DIR_UP] = d[DIR_RT];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] onehot_hi(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (v[DIR_UP])      r[DIR_UP] = 1'b1;
        else if (v[DIR_DN]) r[DIR_DN] = 1'b1;
        else if (v[DIR_LT]) r[DIR_LT] = 1'b1;
        else if (v[DIR_RT]) r[DIR_RT] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] socd_neutral(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[DIR_UP] && d[DIR_DN]) begin
            r[DIR_UP] = 1'b0;
            r[DIR_DN] = 1'b0;
        end
        if (d[DIR_LT] && d[DIR_RT]) begin
            r[DIR_LT] = 1'b0;
            r[DIR_RT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/joy_dir_filter_chan.sv
// ---------------------------------------------------------------------------
// joy_dir_chan
// One player's direction path: 2-flop synchroniser, per-bit debounce,
// restriction mask, rotation and registered output.
// Optional autofire (macro JOY_DIR_FILTER_AUTOFIRE_EN) adds a fire bit that
// shares the sync/debounce path and a half-period toggle counter.
// Ports:
//   i_clk_sys, i_reset : clock, async active-high reset
//   i_ce               : debounce/autofire time-base tick
//   i_mode, i_rotate   : restriction mode and rotation select
//   i_dir              : raw {up,down,left,right}
//   o_dir, o_valid     : filtered direction, 1-cycle change pulse
//   i_fire, i_af_en, o_fire : autofire build only
// ---------------------------------------------------------------------------
module joy_dir_chan
    import joy_dir_pkg::*;
#(
    parameter int DEBOUNCE_W = 4
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    ,
    parameter int AF_W = 4
`endif
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic [1:0] i_mode,
    input  logic [1:0] i_rotate,
    input  logic [3:0] i_dir,
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    input  logic       i_fire,
    input  logic       i_af_en,
    output logic       o_fire,
`endif
    output logic [3:0] o_dir,
    output logic       o_valid
);

`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    // Last count before all-ones: the tick that would reach all-ones commits.
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'((1 << DEBOUNCE_W) - 2);

    logic [NB-1:0]         w_raw;
    logic [NB-1:0]         r_sync1;
    logic [NB-1:0]         r_sync2;
    logic [NB-1:0]         r_stable;
    logic [NB-1:0]         r_stable_d;
    logic [DEBOUNCE_W-1:0] r_cnt [NB];

    logic [3:0] r_mask;
    logic [1:0] r_mode_d;
    logic [3:0] r_dir_out;
    logic       r_valid;

    logic [3:0] w_st;
    logic [3:0] w_new;
    logic       w_mode_chg;
    logic [3:0] w_mask_next;
    logic [3:0] w_filt;
    logic [3:0] w_rot;

`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    assign w_raw = {i_fire, i_dir};
`else
    assign w_raw = i_dir;
`endif

    // NOTE: all state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            // NOTE: counter array is a handful of flops, so it is reset like any register.
            for (int b = 0; b < NB; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int b = 0; b < NB; b++) begin
                if (r_sync2[b] == r_stable[b]) begin
                    r_cnt[b] <= '0;
                end else if (i_ce) begin
                    if (r_cnt[b] == CNT_LAST) begin
                        r_stable[b] <= r_sync2[b];
                        r_cnt[b]    <= '0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    assign w_st       = r_stable[3:0];
    assign w_new      = r_stable[3:0] & ~r_stable_d[3:0];
    assign w_mode_chg = (i_mode != r_mode_d);

    // Output is gated by the next mask so a press from neutral never shows
    // more than one bit in the 4-way modes.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        w_mask_next = 4'b1111;
        w_filt      = w_st;
        case (mode_e'(i_mode))
            MODE_LAST: begin
                if (|w_new)                    w_mask_next = onehot_hi(w_new);
                else if ((w_st & r_mask) == '0) w_mask_next = 4'b1111;
                else                           w_mask_next = r_mask;
            end
            MODE_FIRST: begin
                if (r_mask == 4'b1111)          w_mask_next = (w_st != '0) ? onehot_hi(w_st) : 4'b1111;
                else if ((w_st & r_mask) == '0) w_mask_next = 4'b1111;
                else                           w_mask_next = r_mask;
            end
            default: w_mask_next = 4'b1111;
        endcase
        if (w_mode_chg) w_mask_next = 4'b1111;
        case (mode_e'(i_mode))
            MODE_RAW:  w_filt = w_st;
            MODE_SOCD: w_filt = socd_neutral(w_st);
            default:   w_filt = w_st & w_mask_next;
        endcase
    end

    assign w_rot = rotate_dir(w_filt, rotate_e'(i_rotate));

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_mask    <= 4'b1111;
            r_mode_d  <= '0;
            r_dir_out <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_mask    <= w_mask_next;
            r_mode_d  <= i_mode;
            r_dir_out <= w_rot;
            r_valid   <= (w_rot != r_dir_out);
        end
    end

    assign o_dir   = r_dir_out;
    assign o_valid = r_valid;

`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    logic            w_fire_st;
    logic            w_fire_new;
    logic [AF_W-1:0] r_af_cnt;
    logic            r_fire_out;

    assign w_fire_st  = r_stable[4];
    assign w_fire_new = r_stable[4] & ~r_stable_d[4];

    // Toggle every 2^AF_W ticks while held; the press edge restarts high.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_af_cnt   <= '0;
            r_fire_out <= 1'b0;
        end else if (!i_af_en) begin
            r_af_cnt   <= '0;
            r_fire_out <= w_fire_st;
        end else if (!w_fire_st) begin
            r_af_cnt   <= '0;
            r_fire_out <= 1'b0;
        end else if (w_fire_new) begin
            r_af_cnt   <= '0;
            r_fire_out <= 1'b1;
        end else if (i_ce) begin
            if (r_af_cnt == '1) begin
                r_af_cnt   <= '0;
                r_fire_out <= ~r_fire_out;
            end else begin
                r_af_cnt <= r_af_cnt + 1'b1;
            end
        end
    end

    assign o_fire = r_fire_out;
`endif

endmodule

// File: rtl/joy_dir_filter.sv
// ---------------------------------------------------------------------------
// joy_dir_filter
// Per-player joystick direction conditioning between the joystick mux and
// the core input bytes. One joy_dir_chan per player; buses packed 4 bits
// per player as {up,down,left,right}.
// Optional feature macro: JOY_DIR_FILTER_AUTOFIRE_EN (adds fire_in, af_en,
// fire_out and the autofire counters).
// Ports:
//   clk_sys, reset : system clock, async active-high reset
//   ce             : debounce/autofire tick
//   mode, rotate   : restriction mode and rotation for all players
//   dir_in         : raw directions, 4*NUM_PLAYERS
//   dir_out        : filtered directions, registered
//   dir_valid      : per-player 1-cycle pulse on dir_out change
// ---------------------------------------------------------------------------
module joy_dir_filter
    import joy_dir_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DEBOUNCE_W  = 4,
    parameter int AF_W        = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ce,
    input  logic [1:0]               mode,
    input  logic [1:0]               rotate,
    input  logic [4*NUM_PLAYERS-1:0] dir_in,
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    input  logic [NUM_PLAYERS-1:0]   fire_in,
    input  logic [NUM_PLAYERS-1:0]   af_en,
    output logic [NUM_PLAYERS-1:0]   fire_out,
`endif
    output logic [4*NUM_PLAYERS-1:0] dir_out,
    output logic [NUM_PLAYERS-1:0]   dir_valid
);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        joy_dir_chan #(
            .DEBOUNCE_W(DEBOUNCE_W)
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
            ,
            .AF_W(AF_W)
`endif
        ) u_chan (
            .i_clk_sys(clk_sys),
            .i_reset  (reset),
            .i_ce     (ce),
            .i_mode   (mode),
            .i_rotate (rotate),
            .i_dir    (dir_in[4*p +: 4]),
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
            .i_fire   (fire_in[p]),
            .i_af_en  (af_en[p]),
            .o_fire   (fire_out[p]),
`endif
            .o_dir    (dir_out[4*p +: 4]),
            .o_valid  (dir_valid[p])
        );
    end

`ifndef JOY_DIR_FILTER_AUTOFIRE_EN
    // Autofire is compiled out; AF_W stays so overrides work in both builds.
    if (AF_W < 1) begin : g_af_w_unused
    end
`endif

endmodule

// File: tb/tb_joy_dir_filter.sv
module tb_joy_dir_filter;

    localparam int NP = 2;

    logic            clk_sys;
    logic            reset;
    logic            ce;
    logic [1:0]      mode;
    logic [1:0]      rotate;
    logic [4*NP-1:0] dir_in;
    logic [4*NP-1:0] dir_out;
    logic [NP-1:0]   dir_valid;
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    logic [NP-1:0]   fire_in;
    logic [NP-1:0]   af_en;
    logic [NP-1:0]   fire_out;
`endif

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  d;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_valid = 0;

    joy_dir_filter #(
        .NUM_PLAYERS(NP),
        .DEBOUNCE_W (2),
        .AF_W       (1)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .mode     (mode),
        .rotate   (rotate),
        .dir_in   (dir_in),
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
        .fire_in  (fire_in),
        .af_en    (af_en),
        .fire_out (fire_out),
`endif
        .dir_out  (dir_out),
        .dir_valid(dir_valid)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // ce every 4 clk_sys cycles, changed on the falling edge
    initial begin
        logic [1:0] div;
        div = '0;
        ce  = 1'b0;
        forever begin
            @(negedge clk_sys);
            div = div + 2'd1;
            ce  = (div == 2'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: every dir_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                for (int p = 0; p < NP; p++) begin
                    if (dir_valid[p]) begin
                        n_valid++;
                        n_total++;
                        if (q.size() == 0) begin
                            $display("FAIL unexpected_valid: player %0d dir_out=%b with nothing expected",
                                     p, dir_out[4*p +: 4]);
                        end else begin
                            e = q.pop_front();
                            if (e.p !== 32'(p) || dir_out[4*p +: 4] !== e.d)
                                $display("FAIL scoreboard: player %0d dir_out=%b, expected player %0d dir_out=%b",
                                         p, dir_out[4*p +: 4], e.p, e.d);
                            else
                                n_pass++;
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int p, input logic [3:0] d);
        exp_t e;
        e.p = 32'(p);
        e.d = d;
        q.push_back(e);
    endtask

    task automatic wait_ce(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            while (!ce) @(posedge clk_sys);
        end
    endtask

    task automatic settle();
        wait_ce(5);
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic set_p0(input logic [3:0] d);
        @(negedge clk_sys);
        dir_in[3:0] = d;
    endtask

    task automatic check_p0(input string name, input logic [3:0] exp);
        n_total++;
        if (dir_out[3:0] !== exp)
            $display("FAIL %s: dir_out=%b expected %b", name, dir_out[3:0], exp);
        else
            n_pass++;
        n_total++;
        if (q.size() != 0)
            $display("FAIL %s_pending: %0d expected pulses not seen, expected 0", name, q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        dir_in = '0;
        mode   = 2'd0;
        rotate = 2'd0;
        repeat (3) @(negedge clk_sys);
        n_total++;
        if (dir_out !== '0) $display("FAIL reset_dir_out: got %b expected 0", dir_out);
        else n_pass++;
        n_total++;
        if (dir_valid !== '0) $display("FAIL reset_dir_valid: got %b expected 0", dir_valid);
        else n_pass++;
        reset = 1'b0;
        repeat (4) @(posedge clk_sys);

        set_p0(4'b1000);
        repeat (2) @(posedge clk_sys);
        wait_ce(2);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        n_total++;
        if (dir_out !== '0) $display("FAIL reset_mid_debounce: got %b expected 0", dir_out);
        else n_pass++;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(posedge clk_sys);
        wait_ce(2);
        repeat (2) @(posedge clk_sys);
        #1;
        n_total++;
        if (dir_out[3:0] !== 4'b0000) $display("FAIL up_after_2_ticks: got %b expected 0000", dir_out[3:0]);
        else n_pass++;
        push(0, 4'b1000);
        wait_ce(1);
        @(posedge clk_sys);
        #1;
        n_total++;
        if (dir_out[3:0] !== 4'b1000) $display("FAIL up_after_3_ticks: got %b expected 1000", dir_out[3:0]);
        else n_pass++;
        push(0, 4'b0000);
        set_p0(4'b0000);
        settle();
        check_p0("reset_release", 4'b0000);
    endtask

    task automatic test_glitch();
        int v0;
        v0 = n_valid;
        set_p0(4'b0010);
        repeat (2) @(posedge clk_sys);
        wait_ce(1);
        set_p0(4'b0000);
        repeat (40) @(posedge clk_sys);
        #1;
        check_p0("glitch_dir_out", 4'b0000);
        n_total++;
        if (n_valid !== v0) $display("FAIL glitch_no_valid: %0d pulses expected 0", n_valid - v0);
        else n_pass++;
    endtask

    task automatic test_mode_last();
        @(negedge clk_sys);
        mode = 2'd2;
        push(0, 4'b0001); set_p0(4'b0001); settle(); check_p0("last_right", 4'b0001);
        push(0, 4'b1000); set_p0(4'b1001); settle(); check_p0("last_add_up", 4'b1000);
        push(0, 4'b0001); set_p0(4'b0001); settle(); check_p0("last_rel_up", 4'b0001);
        push(0, 4'b0000); set_p0(4'b0000); settle(); check_p0("last_rel_all", 4'b0000);
    endtask

    task automatic test_mode_first();
        @(negedge clk_sys);
        mode = 2'd3;
        push(0, 4'b0001); set_p0(4'b0001); settle(); check_p0("first_right", 4'b0001);
        set_p0(4'b1001); settle(); check_p0("first_add_up", 4'b0001);
        push(0, 4'b1000); set_p0(4'b1000); settle(); check_p0("first_rel_right", 4'b1000);
        push(0, 4'b0000); set_p0(4'b0000); settle(); check_p0("first_rel_all", 4'b0000);
    endtask

    task automatic test_mode_socd();
        @(negedge clk_sys);
        mode = 2'd1;
        push(0, 4'b1000); set_p0(4'b1011); settle(); check_p0("socd_lru", 4'b1000);
        push(0, 4'b1011);
        @(negedge clk_sys);
        mode = 2'd0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_p0("raw_lru", 4'b1011);
        push(0, 4'b0000); set_p0(4'b0000); settle(); check_p0("raw_rel", 4'b0000);
    endtask

    task automatic test_rotate();
        @(negedge clk_sys);
        rotate = 2'd1;
        push(0, 4'b0001); set_p0(4'b1000); settle(); check_p0("rot_cw_up", 4'b0001);
        push(0, 4'b0100);
        @(negedge clk_sys);
        rotate = 2'd2;
        repeat (3) @(posedge clk_sys);
        #1;
        check_p0("rot_180_up", 4'b0100);
        push(0, 4'b0010);
        @(negedge clk_sys);
        rotate = 2'd3;
        repeat (3) @(posedge clk_sys);
        #1;
        check_p0("rot_ccw_up", 4'b0010);
        push(0, 4'b1000);
        @(negedge clk_sys);
        rotate = 2'd0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_p0("rot_none_up", 4'b1000);
        push(0, 4'b0000); set_p0(4'b0000); settle(); check_p0("rot_rel", 4'b0000);
    endtask

    task automatic test_player1();
        push(1, 4'b0100);
        @(negedge clk_sys);
        dir_in[7:4] = 4'b0100;
        settle();
        n_total++;
        if (dir_out !== 8'b0100_0000) $display("FAIL player1_down: dir_out=%b expected 01000000", dir_out);
        else n_pass++;
        push(1, 4'b0000);
        @(negedge clk_sys);
        dir_in[7:4] = 4'b0000;
        settle();
        n_total++;
        if (dir_out !== 8'b0 || q.size() != 0)
            $display("FAIL player1_release: dir_out=%b pending=%0d expected 0/0", dir_out, q.size());
        else n_pass++;
    endtask

`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
    task automatic test_autofire();
        bit seen;
        af_en[0]   = 1'b0;
        fire_in[0] = 1'b1;
        settle();
        n_total++;
        if (fire_out[0] !== 1'b1) $display("FAIL fire_passthru: got %b expected 1", fire_out[0]);
        else n_pass++;
        @(negedge clk_sys);
        fire_in[0] = 1'b0;
        settle();
        @(negedge clk_sys);
        af_en[0]   = 1'b1;
        fire_in[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_sys);
            seen = fire_out[0];
        end
        n_total++;
        if (!seen) $display("FAIL af_first_high: fire_out never rose, expected 1");
        else n_pass++;
        wait_ce(1); #1;
        n_total++;
        if (fire_out[0] !== 1'b1) $display("FAIL af_tick1: got %b expected 1", fire_out[0]);
        else n_pass++;
        wait_ce(1); #1;
        n_total++;
        if (fire_out[0] !== 1'b0) $display("FAIL af_tick2: got %b expected 0", fire_out[0]);
        else n_pass++;
        wait_ce(2); #1;
        n_total++;
        if (fire_out[0] !== 1'b1) $display("FAIL af_tick4: got %b expected 1", fire_out[0]);
        else n_pass++;
        @(negedge clk_sys);
        fire_in[0] = 1'b0;
        settle();
        n_total++;
        if (fire_out[0] !== 1'b0) $display("FAIL af_release: got %b expected 0", fire_out[0]);
        else n_pass++;
    endtask
`endif

    initial begin
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
        fire_in = '0;
        af_en   = '0;
`endif
        test_reset();
        test_glitch();
        test_mode_last();
        test_mode_first();
        test_mode_socd();
        test_rotate();
        test_player1();
`ifdef JOY_DIR_FILTER_AUTOFIRE_EN
        test_autofire();
`endif
        repeat (4) @(posedge clk_sys);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
